// File: rtl/rate_tick_pkg.sv
// Shared types and helpers for the rate tick generator.
// Tap positions are computed here so that the tap mux and the elaboration check agree.
package rate_tick_pkg;

  typedef enum logic [1:0] {
    STOPPED   = 2'd0,
    RUNNING   = 2'd1,
    SWITCHING = 2'd2
  } state_t;

  // Out-of-range rate requests fall back to the slowest implemented rate.
  function automatic int unsigned clamp_sel(input int unsigned sel,
                                            input int unsigned num_rates);
    return (sel >= num_rates) ? (num_rates - 1) : sel;
  endfunction

  function automatic int unsigned tap_idx(input int unsigned k,
                                          input int unsigned base,
                                          input int unsigned step);
    return base + k * step;
  endfunction

endpackage

// File: rtl/rate_tick_tap_mux.sv
// Combinational selector: picks the counter bit that drives rate index 'rate'.
module rate_tick_tap_mux
  import rate_tick_pkg::*;
#(
  parameter  int unsigned CNT_W     = 27,
  parameter  int unsigned NUM_RATES = 4,
  parameter  int unsigned TAP_BASE  = 20,
  parameter  int unsigned TAP_STEP  = 2,
  localparam int unsigned SEL_W     = $clog2(NUM_RATES)
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic [SEL_W-1:0] rate,
  output logic             tap
);

  logic [NUM_RATES-1:0] taps;
  logic                 unused_cnt;

  // Only the tap bits matter; the rest of the counter is deliberately ignored.
  assign unused_cnt = ^cnt;

  for (genvar k = 0; k < NUM_RATES; k++) begin : g_tap
    localparam int unsigned IDX = tap_idx(k, TAP_BASE, TAP_STEP);
    assign taps[k] = cnt[IDX];
  end

  always_comb begin
    tap = 1'b0;
    for (int unsigned k = 0; k < NUM_RATES; k++) begin
      if (rate == SEL_W'(k)) tap = taps[k];
    end
  end

endmodule

// File: rtl/rate_tick_gen.sv
// Run-time selectable rate generator: square-wave slow_clk plus 1-cycle tick enable.
// Optional feature macro: RATE_TICK_STEP_EN (adds the step port for single-stepping while stopped).
module rate_tick_gen
  import rate_tick_pkg::*;
#(
  parameter  int unsigned CNT_W     = 27,
  parameter  int unsigned NUM_RATES = 4,
  parameter  int unsigned TAP_BASE  = 20,
  parameter  int unsigned TAP_STEP  = 2,
  localparam int unsigned SEL_W     = $clog2(NUM_RATES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [SEL_W-1:0] rate_sel,
`ifdef RATE_TICK_STEP_EN
  input  logic             step,
`endif
  output logic             slow_clk,
  output logic             tick,
  output logic [SEL_W-1:0] rate_cur,
  output logic             switching
);

  if (NUM_RATES < 2) begin : g_bad_rates
    $error("rate_tick_gen: NUM_RATES must be at least 2");
  end
  if (tap_idx(NUM_RATES - 1, TAP_BASE, TAP_STEP) >= CNT_W) begin : g_bad_tap
    $error("rate_tick_gen: highest rate tap lies outside the counter");
  end

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [SEL_W-1:0] req, rate_cur_next;
  logic             tap_cur, tap_req;
  logic             commit, pend_next;
  logic             slow_clk_next, tick_next;
  logic             stop_pend;

  assign req      = SEL_W'(clamp_sel(32'(rate_sel), NUM_RATES));
  assign cnt_next = run ? (cnt + CNT_W'(1)) : cnt;

  // Commit only from a low phase into a low tap, so no high phase is cut short
  // and the new rate's first high phase begins on its own counter edge.
  assign commit        = run & (req != rate_cur) & ~slow_clk & ~tap_req;
  assign rate_cur_next = commit ? req : rate_cur;
  assign pend_next     = (req != rate_cur_next);

  rate_tick_tap_mux #(
    .CNT_W    (CNT_W),
    .NUM_RATES(NUM_RATES),
    .TAP_BASE (TAP_BASE),
    .TAP_STEP (TAP_STEP)
  ) u_tap_req (
    .cnt (cnt_next),
    .rate(req),
    .tap (tap_req)
  );

  rate_tick_tap_mux #(
    .CNT_W    (CNT_W),
    .NUM_RATES(NUM_RATES),
    .TAP_BASE (TAP_BASE),
    .TAP_STEP (TAP_STEP)
  ) u_tap_cur (
    .cnt (cnt_next),
    .rate(rate_cur_next),
    .tap (tap_cur)
  );

  assign slow_clk_next = run ? tap_cur : slow_clk;

`ifdef RATE_TICK_STEP_EN
  logic step_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_q <= 1'b0;
    else        step_q <= step;
  end

  assign tick_next = (run & ~slow_clk & slow_clk_next) | (~run & step & ~step_q);
`else
  assign tick_next = run & ~slow_clk & slow_clk_next;
`endif

  always_comb begin
    state_next = state;
    unique case (state)
      STOPPED: begin
        if (run) state_next = pend_next ? SWITCHING : RUNNING;
      end
      RUNNING, SWITCHING: begin
        if (!run)           state_next = STOPPED;
        else if (pend_next) state_next = SWITCHING;
        else                state_next = RUNNING;
      end
      default: state_next = STOPPED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= STOPPED;
      cnt       <= '0;
      rate_cur  <= '0;
      slow_clk  <= 1'b0;
      tick      <= 1'b0;
      stop_pend <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      rate_cur  <= rate_cur_next;
      slow_clk  <= slow_clk_next;
      tick      <= tick_next;
      stop_pend <= ~run & pend_next;
    end
  end

  // A request pending while stopped is remembered separately from the FSM state.
  assign switching = (state == SWITCHING) | stop_pend;

endmodule
